pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 4 in 8..64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in cycles; legal values are 1..WIDTH/4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts operand beat this cycle.
REQ-007 SHALL have port A  input  WIDTH  first operand.
REQ-008 SHALL have port B  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = A+B+cin, 1 = A+~B+1 (cin ignored).
REQ-010 SHALL have port cin  input  1  carry-in for add mode.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result beat.
REQ-013 SHALL have port rslt  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 SHALL have port cout  output  1  carry out of MSB (in sub mode, 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port zero  output  1  rslt == 0.

Function
REQ-017 SHALL split operands into WIDTH/4 groups of 4 bits, each with a 4-bit carry-look-ahead unit producing group propagate/generate (P = a|b, G = a&b per bit).
REQ-018 SHALL assign groups to stages lowest-first, contiguously, with group counts per stage differing by at most one and earlier stages taking the extra group.
REQ-019 SHALL resolve group carries within a stage by look-ahead and register the stage-boundary carry, the completed low result bits and the unprocessed high operand bits.
REQ-020 SHALL produce each result exactly STAGES cycles after acceptance when out_ready stays high.
REQ-021 SHALL accept a beat when in_valid && in_ready; SHALL deliver a beat when out_valid && out_ready.
REQ-022 SHALL advance stage k when stage k is empty or stage k+1 advances; the last stage advances when out_ready is high or it is empty.
REQ-023 SHALL drive in_ready equal to stage-0 advance; in_ready may depend combinationally on out_ready.
REQ-024 SHALL sustain one beat per cycle with in_valid and out_ready continuously high.
REQ-025 SHALL hold rslt, cout, ovf, zero stable while out_valid && !out_ready.
REQ-026 SHALL never drop, duplicate or reorder beats; holds up to STAGES beats.
REQ-027 SHALL compute ovf = (opA[MSB] == opB'[MSB]) && (rslt[MSB] != opA[MSB]), where opB' is the effective second operand (B or ~B).
REQ-028 SHALL capture the sub/cin mode per beat; a mode change on consecutive beats has no effect on in-flight beats.
REQ-029 SHALL leave outputs registered, with no combinational path from A, B, sub or cin to any output.

Reset
REQ-030 SHALL, on a clk edge with rst high, clear every stage valid bit; out_valid = 0, rslt = 0, cout = 0, ovf = 0, zero = 0 from the next cycle.
REQ-031 SHALL discard in-flight beats on reset mid-operation; the first beat accepted after rst falls is the first delivered.
REQ-032 SHALL hold in_ready low while rst is high.

Verification (WIDTH=32, STAGES=2)
REQ-033 SHALL cover add rollover: A=FFFFFFFF, B=00000001, sub=0, cin=0 -> after 2 cycles rslt=00000000, cout=1, ovf=0, zero=1.
REQ-034 SHALL cover subtract overflow: A=80000000, B=00000001, sub=1 -> rslt=7FFFFFFF, cout=1, ovf=1, zero=0.
REQ-035 SHALL cover carry chain across the stage boundary: A=0000FFFF, B=00000001, cin=1 -> rslt=00010001, cout=0, ovf=0.
REQ-036 SHALL cover backpressure: 3 back-to-back beats (1+1, 2+2, 3+3); out_ready low for 4 cycles after the first result -> in_ready low once full, results 2, 4, 6 in order, each held stable while stalled.
REQ-037 SHALL cover reset mid-flight: 2 beats accepted, rst pulsed 1 cycle -> no result delivered; next beat 5+7 -> rslt=0000000C exactly 2 cycles after acceptance.
REQ-038 SHALL cover random streams against a reference model, for STAGES 1 and WIDTH/4 and random in_valid/out_ready, with zero mismatches over 10000 beats.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor: 4-bit CLA groups spread over STAGES register stages.
// Latency STAGES cycles; valid/ready with per-stage advance so a stall collapses bubbles before reaching in_ready.

module pipelined_cla_adder_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       gp,
   output logic       gg
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   assign p = a | b;
   assign g = a & b;

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

   assign s  = a ^ b ^ c;
   assign gp = &p;
   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module pipelined_cla_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rslt,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int NG    = WIDTH / 4;
   localparam int BASE  = NG / STAGES;
   localparam int EXTRA = NG % STAGES;

   // First group index of stage s; earlier stages absorb the remainder groups.
   function automatic int grp_lo(input int s);
      return s * BASE + ((s < EXTRA) ? s : EXTRA);
   endfunction

   logic [STAGES:0] adv;

   assign adv[STAGES] = out_ready;
   assign in_ready    = adv[0] & ~rst;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int LO = grp_lo(k);
      localparam int HI = grp_lo(k + 1);

      // xa carries finished sum bits below LO*4 and still-raw A bits above.
      logic [WIDTH-1:0]      xa;
      logic [WIDTH-1:LO*4]   bb;
      logic                  ci;
      logic                  iv;
      logic [HI-1:LO]        gp;
      logic [HI-1:LO]        gg;
      logic [HI:LO]          gc;
      logic [HI*4-1:LO*4]    sm;
      logic [WIDTH-1:0]      xs;

      if (k == 0) begin : g_src
         assign xa = A;
         assign bb = sub ? ~B : B;
         assign ci = sub | cin;
         assign iv = in_valid;
      end else begin : g_src
         assign xa = stg[k-1].g_pipe.x_q;
         assign bb = stg[k-1].g_pipe.b_q;
         assign ci = stg[k-1].g_pipe.c_q;
         assign iv = stg[k-1].g_pipe.v_q;
      end

      for (genvar g = LO; g < HI; g++) begin : grp
         pipelined_cla_adder_cla4 u_cla (
            .a  (xa[4*g +: 4]),
            .b  (bb[4*g +: 4]),
            .ci (gc[g]),
            .s  (sm[4*g +: 4]),
            .gp (gp[g]),
            .gg (gg[g])
         );
      end

      always_comb begin
         gc     = '0;
         gc[LO] = ci;
         for (int j = LO; j < HI; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
         end
      end

      always_comb begin
         xs               = xa;
         xs[HI*4-1:LO*4]  = sm;
      end

      if (k < STAGES - 1) begin : g_pipe
         logic                  v_q;
         logic                  c_q;
         logic [WIDTH-1:0]      x_q;
         logic [WIDTH-1:HI*4]   b_q;

         assign adv[k] = ~v_q | adv[k+1];

         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= 1'b0;
            end else begin
               if (adv[k]) begin
                  v_q <= iv;
               end
               if (adv[k] && iv) begin
                  x_q <= xs;
                  b_q <= bb[WIDTH-1:HI*4];
                  c_q <= gc[HI];
               end
            end
         end
      end else begin : g_out
         assign adv[k] = ~out_valid | adv[k+1];

         // The MSB group always lives in the last stage, so raw sign bits are still at hand here.
         always_ff @(posedge clk) begin
            if (rst) begin
               out_valid <= 1'b0;
               rslt      <= '0;
               cout      <= 1'b0;
               ovf       <= 1'b0;
               zero      <= 1'b0;
            end else begin
               if (adv[k]) begin
                  out_valid <= iv;
               end
               if (adv[k] && iv) begin
                  rslt <= xs;
                  cout <= gc[HI];
                  ovf  <= (xa[WIDTH-1] == bb[WIDTH-1]) && (xs[WIDTH-1] != xa[WIDTH-1]);
                  zero <= ~|xs;
               end
            end
         end
      end
   end
endmodule
